// File: rtl/bbc_keyboard_matrix.sv
// PS/2 set-2 receiver feeding a BBC Micro 10x8 key matrix that answers
// System VIA probes like the original LS251/LS163 keyboard circuit.
module bbc_keyboard_matrix #(
  parameter int TIMEOUT = 1024
) (
  input  logic       clk,
  input  logic       nRESET,
  input  logic       clk_en,
  input  logic       autoscan,
  input  logic [3:0] column,
  input  logic [2:0] row,
  input  logic       PS2_CLK,
  input  logic       PS2_DATA,
  output logic       column_match,
  output logic       row_match
);

  localparam int TW = $clog2(TIMEOUT + 1);

  logic [1:0]       ck_s_q;
  logic [1:0]       dt_s_q;
  logic             ck_prev_q;
  logic [9:0]       bits_q;
  logic [3:0]       cnt_q;
  logic [TW-1:0]    to_q;
  logic             ext_q;
  logic             brk_q;
  logic [3:0]       scan_q;
  logic [15:0][7:0] mat_q;

  logic       fall;
  logic       din;
  logic       frame_ok;
  logic [7:0] code;
  logic [7:0] map;
  logic [3:0] col_eff;
  logic [7:0] colv;

  // Returns {hit, row[2:0], col[3:0]} for a set-2 code.
  function automatic logic [7:0] lookup(input logic e, input logic [7:0] c);
    logic       hit;
    logic [6:0] rc;
    hit = 1'b1;
    rc  = 7'h00;
    case ({e, c})
      9'h015: rc = 7'h10; 9'h01D: rc = 7'h21; 9'h024: rc = 7'h22;
      9'h02D: rc = 7'h33; 9'h02C: rc = 7'h23; 9'h035: rc = 7'h44;
      9'h03C: rc = 7'h35; 9'h043: rc = 7'h25; 9'h044: rc = 7'h36;
      9'h04D: rc = 7'h37;
      9'h01C: rc = 7'h41; 9'h01B: rc = 7'h51; 9'h023: rc = 7'h32;
      9'h02B: rc = 7'h43; 9'h034: rc = 7'h53; 9'h033: rc = 7'h54;
      9'h03B: rc = 7'h45; 9'h042: rc = 7'h46; 9'h04B: rc = 7'h56;
      9'h01A: rc = 7'h61; 9'h022: rc = 7'h42; 9'h021: rc = 7'h52;
      9'h02A: rc = 7'h63; 9'h032: rc = 7'h64; 9'h031: rc = 7'h55;
      9'h03A: rc = 7'h65;
      9'h016: rc = 7'h30; 9'h01E: rc = 7'h31; 9'h026: rc = 7'h11;
      9'h025: rc = 7'h12; 9'h02E: rc = 7'h13; 9'h036: rc = 7'h34;
      9'h03D: rc = 7'h24; 9'h03E: rc = 7'h15; 9'h046: rc = 7'h26;
      9'h045: rc = 7'h27;
      9'h029: rc = 7'h62; 9'h05A: rc = 7'h49; 9'h076: rc = 7'h70;
      9'h012: rc = 7'h00; 9'h059: rc = 7'h00; 9'h014: rc = 7'h01;
      9'h058: rc = 7'h40; 9'h00D: rc = 7'h60; 9'h066: rc = 7'h59;
      9'h069: rc = 7'h69;
      9'h009: rc = 7'h20; 9'h005: rc = 7'h71; 9'h006: rc = 7'h72;
      9'h004: rc = 7'h73; 9'h00C: rc = 7'h14; 9'h003: rc = 7'h74;
      9'h00B: rc = 7'h75; 9'h083: rc = 7'h16; 9'h00A: rc = 7'h76;
      9'h001: rc = 7'h77;
      9'h04E: rc = 7'h17; 9'h055: rc = 7'h18; 9'h054: rc = 7'h47;
      9'h05B: rc = 7'h58; 9'h041: rc = 7'h66; 9'h049: rc = 7'h67;
      9'h04A: rc = 7'h68; 9'h04C: rc = 7'h57; 9'h052: rc = 7'h48;
      9'h05D: rc = 7'h78;
      9'h175: rc = 7'h39; 9'h172: rc = 7'h29; 9'h16B: rc = 7'h19;
      9'h174: rc = 7'h79;
      default: hit = 1'b0;
    endcase
    return {hit, rc};
  endfunction

  always_comb begin
    fall     = ck_prev_q & ~ck_s_q[1];
    din      = dt_s_q[1];
    code     = bits_q[8:1];
    frame_ok = fall && (cnt_q == 4'd10) && !bits_q[0] && din
               && (^bits_q[9:1]);
    map      = lookup(ext_q, code);
    col_eff  = autoscan ? scan_q : column;
    colv     = mat_q[col_eff];
    // Startup-link positions in row 0 always read as open.
    row_match    = colv[row] & ~((row == 3'd0) && (col_eff >= 4'd2));
    column_match = |colv[7:1];
  end

  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      ck_s_q    <= 2'b11;
      dt_s_q    <= 2'b11;
      ck_prev_q <= 1'b1;
      bits_q    <= '0;
      cnt_q     <= '0;
      to_q      <= '0;
      ext_q     <= 1'b0;
      brk_q     <= 1'b0;
      scan_q    <= '0;
      mat_q     <= '0;
    end else if (clk_en) begin
      ck_s_q    <= {ck_s_q[0], PS2_CLK};
      dt_s_q    <= {dt_s_q[0], PS2_DATA};
      ck_prev_q <= ck_s_q[1];
      scan_q    <= autoscan ? scan_q + 4'd1 : column;

      if (fall) begin
        to_q <= '0;
        if (cnt_q == 4'd10) begin
          cnt_q <= '0;
        end else begin
          bits_q[cnt_q] <= din;
          cnt_q         <= cnt_q + 4'd1;
        end
      end else if ((cnt_q != 4'd0) && ck_s_q[1]) begin
        if (to_q == TW'(TIMEOUT - 1)) begin
          cnt_q <= '0;
          to_q  <= '0;
        end else begin
          to_q <= to_q + 1'b1;
        end
      end else begin
        to_q <= '0;
      end

      if (frame_ok) begin
        if (code == 8'hE0) begin
          ext_q <= 1'b1;
        end else if (code == 8'hF0) begin
          brk_q <= 1'b1;
        end else begin
          ext_q <= 1'b0;
          brk_q <= 1'b0;
          if (map[7]) mat_q[map[3:0]][map[6:4]] <= ~brk_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_bbc_keyboard_matrix.sv
// Directed bench for bbc_keyboard_matrix: PS/2 frames in,
// matrix probes out, against hand-derived key positions.
module tb_bbc_keyboard_matrix;

  logic       clk = 1'b0;
  logic       clk_en = 1'b0;
  logic       nRESET;
  logic       autoscan;
  logic [3:0] column;
  logic [2:0] row;
  logic       PS2_CLK;
  logic       PS2_DATA;
  logic       column_match;
  logic       row_match;

  int checks = 0;
  int errors = 0;
  int unsigned div = 0;

  bbc_keyboard_matrix #(.TIMEOUT(1024)) dut (
    .clk          (clk),
    .nRESET       (nRESET),
    .clk_en       (clk_en),
    .autoscan     (autoscan),
    .column       (column),
    .row          (row),
    .PS2_CLK      (PS2_CLK),
    .PS2_DATA     (PS2_DATA),
    .column_match (column_match),
    .row_match    (row_match)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    div = div + 1;
    clk_en = div[0];
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      while (!clk_en) @(posedge clk);
    end
    #1;
  endtask

  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      PS2_DATA = f[i];
      tick(2);
      PS2_CLK = 1'b0;
      tick(3);
      PS2_CLK = 1'b1;
    end
  endtask

  task automatic frame(input logic [7:0] b, input bit bad);
    logic p;
    p = (~^b) ^ bad;
    send_bits({1'b1, p, b, 1'b0}, 11);
    tick(4);
  endtask

  task automatic send(input logic [7:0] b);
    frame(b, 1'b0);
  endtask

  task automatic probe(input logic [3:0] c, input logic [2:0] r);
    column = c;
    row    = r;
    #1;
  endtask

  task automatic count_set(output int n, output int cm);
    n  = 0;
    cm = 0;
    for (int c = 0; c < 16; c++) begin
      for (int r = 0; r < 8; r++) begin
        probe(4'(c), 3'(r));
        n  += int'(row_match);
        cm += int'(column_match);
      end
    end
  endtask

  int n;
  int cm;
  int hits;
  int first;
  int gap;

  initial begin
    nRESET   = 1'b0;
    autoscan = 1'b0;
    column   = 4'd1;
    row      = 3'd4;
    PS2_CLK  = 1'b1;
    PS2_DATA = 1'b1;
    #1;
    check("rst_rm", row_match, 0);
    check("rst_cm", column_match, 0);
    tick(3);
    nRESET = 1'b1;
    tick(3);
    count_set(n, cm);
    check("rst_scan_rm", n, 0);
    check("rst_scan_cm", cm, 0);

    send(8'h1C);
    probe(1, 4);
    check("a_make_rm", row_match, 1);
    check("a_make_cm", column_match, 1);
    send(8'hF0); send(8'h1C);
    check("a_brk_rm", row_match, 0);
    check("a_brk_cm", column_match, 0);

    send(8'h12);
    probe(0, 0);
    check("lsh_rm", row_match, 1);
    check("lsh_cm", column_match, 0);
    send(8'h59);
    check("rsh_rm", row_match, 1);
    send(8'hF0); send(8'h12);
    check("sh_brk", row_match, 0);

    send(8'hE0); send(8'h75);
    probe(9, 3);
    check("up_rm", row_match, 1);
    send(8'h75);
    count_set(n, cm);
    check("bare75_cnt", n, 1);

    frame(8'h1C, 1'b1);
    probe(1, 4);
    check("badpar_rm", row_match, 0);

    send_bits({1'b1, 1'b1, 8'h1C, 1'b0}, 5);
    tick(1100);
    send(8'h29);
    probe(2, 6);
    check("space_rm", row_match, 1);
    count_set(n, cm);
    check("space_cnt", n, 2);

    send(8'hE0); send(8'hF0); send(8'h75);
    send(8'hF0); send(8'h29);
    count_set(n, cm);
    check("clr_cnt", n, 0);

    send(8'h83);
    probe(6, 1);
    check("f7_rm", row_match, 1);
    send(8'hF0); send(8'h83);
    check("f7_brk", row_match, 0);

    send(8'h1C); send(8'h1C);
    count_set(n, cm);
    check("dup_cnt", n, 1);
    send(8'hF0); send(8'h1C);
    count_set(n, cm);
    check("dup_brk_cnt", n, 0);

    send(8'h1C);
    send(8'hF0);
    send_bits({1'b1, 1'b1, 8'h1C, 1'b0}, 5);
    nRESET = 1'b0;
    probe(1, 4);
    check("async_clr", row_match, 0);
    tick(2);
    nRESET = 1'b1;
    tick(2);
    send(8'h1C);
    check("post_rst_make", row_match, 1);

    autoscan = 1'b1;
    hits  = 0;
    first = -1;
    gap   = 0;
    for (int t = 0; t < 32; t++) begin
      tick(1);
      if (column_match) begin
        hits++;
        if (first < 0) first = t;
        else gap = t - first;
      end
    end
    check("scan_hits", hits, 2);
    check("scan_gap", gap, 16);
    autoscan = 1'b0;
    probe(5, 4);
    check("col5_cm", column_match, 0);
    probe(1, 4);
    check("col1_cm", column_match, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
